mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 3-input select mux (a/b/c data, s1/s0 select) among three requesters. Each requester raises a request line and receives a one-hot grant. The arbiter drives s1/s0 so the mux output follows the current owner. A one-cycle dead gap is inserted between owners so downstream logic never sees a same-cycle handoff.

---
 rtl/mux_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for the shared 3-input select mux, with a one-cycle dead gap between owners.
// Define MUX_ARB_TIMEOUT_EN to build the hold counter that forces a handoff after HOLD_MAX grant cycles.
module mux_rr_arbiter #(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   output logic [2:0] grant,
   output logic       s1,
   output logic       s0,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t     state_q, state_d;
   logic [2:0] grant_q, grant_d;
   logic [1:0] sel_q, sel_d;
   logic       busy_q, busy_d;
   logic [1:0] ptr_q, ptr_d;
   logic       win_vld;
   logic [1:0] win_idx;
   logic [1:0] cand;
   logic       timeout;

`ifdef MUX_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // cnt_q counts completed grant cycles, so the edge ending cycle HOLD_MAX sees HOLD_MAX-1
   assign timeout = (cnt_q == CNT_W'(HOLD_MAX - 1));
`else
   assign timeout = 1'b0;
`endif

   // Search starts one past the last owner, wrapping a->b->c->a
   always_comb begin
      win_vld = 1'b0;
      win_idx = ptr_q;
      cand    = 2'd0;
      for (int k = 1; k <= 3; k++) begin
         cand = 2'((int'(ptr_q) + k) % 3);
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      ptr_d   = ptr_q;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE, GAP: begin
            if (win_vld) begin
               state_d = GRANT;
               grant_d = 3'b001 << win_idx;
               sel_d   = win_idx;
               busy_d  = 1'b1;
               ptr_d   = win_idx;
`ifdef MUX_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else begin
               state_d = IDLE;
               grant_d = 3'b000;
               busy_d  = 1'b0;
            end
         end
         GRANT: begin
            // Other requesters are not looked at here; they wait for the gap
            if (!req[ptr_q] || timeout) begin
               state_d = GAP;
               grant_d = 3'b000;
               busy_d  = 1'b0;
            end else begin
`ifdef MUX_ARB_TIMEOUT_EN
               cnt_d   = cnt_q + 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 3'b000;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 3'b000;
         sel_q   <= 2'b00;
         busy_q  <= 1'b0;
         ptr_q   <= 2'd2;
`ifdef MUX_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
`ifdef MUX_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign grant = grant_q;
   assign s1    = sel_q[1];
   assign s0    = sel_q[0];
   assign busy  = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: each step queues the expected post-edge outputs, then pops and checks them.
module tb_mux_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] req;
   logic [2:0] grant;
   logic       s1, s0, busy;

   typedef struct packed {
      logic [2:0] grant;
      logic [1:0] sel;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   mux_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .req(req),
      .grant(grant), .s1(s1), .s0(s0), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step(input logic rst, input logic [2:0] r,
                       input logic [2:0] eg, input logic [1:0] es, input logic eb,
                       input string tag);
      exp_t e, obs;
      exp_q.push_back('{grant: eg, sel: es, busy: eb});
      reset = rst;
      req   = r;
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      obs = '{grant: grant, sel: {s1, s0}, busy: busy};
      n_assert++;
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL %s: got grant=%b s1s0=%b busy=%b, want grant=%b s1s0=%b busy=%b",
                tag, obs.grant, obs.sel, obs.busy, e.grant, e.sel, e.busy);
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = 3'b000;
      @(negedge clk);

      // Reset and quiet idle
      step(1, 3'b000, 3'b000, 2'b00, 0, "reset");
      for (int i = 0; i < 5; i++) step(0, 3'b000, 3'b000, 2'b00, 0, "idle_quiet");

      // b alone for 3 cycles, then release: one gap, then idle with select held
      for (int i = 0; i < 3; i++) step(0, 3'b010, 3'b010, 2'b01, 1, "b_grant");
      step(0, 3'b000, 3'b000, 2'b01, 0, "b_gap");
      step(0, 3'b000, 3'b000, 2'b01, 0, "b_idle_hold");

      // a owns, c requests mid-grant without preempting, handoff through one gap
      step(0, 3'b001, 3'b001, 2'b00, 1, "a_grant");
      step(0, 3'b101, 3'b001, 2'b00, 1, "a_hold_c_waits");
      step(0, 3'b101, 3'b001, 2'b00, 1, "a_hold_c_waits2");
      step(0, 3'b100, 3'b000, 2'b00, 0, "a_to_gap");
      step(0, 3'b100, 3'b100, 2'b10, 1, "c_after_gap");
      step(0, 3'b000, 3'b000, 2'b10, 0, "c_gap");
      step(0, 3'b000, 3'b000, 2'b10, 0, "c_idle_hold");

      // All three requesting; pointer is at c so a wins first
`ifdef MUX_ARB_TIMEOUT_EN
      for (int i = 0; i < 8; i++) step(0, 3'b111, 3'b001, 2'b00, 1, "rr_a");
      step(0, 3'b111, 3'b000, 2'b00, 0, "rr_gap_a");
      for (int i = 0; i < 8; i++) step(0, 3'b111, 3'b010, 2'b01, 1, "rr_b");
      step(0, 3'b111, 3'b000, 2'b01, 0, "rr_gap_b");
      for (int i = 0; i < 8; i++) step(0, 3'b111, 3'b100, 2'b10, 1, "rr_c");
      step(0, 3'b111, 3'b000, 2'b10, 0, "rr_gap_c");
      step(0, 3'b111, 3'b001, 2'b00, 1, "rr_a_again");
      step(0, 3'b000, 3'b000, 2'b00, 0, "rr_drop_gap");
      step(0, 3'b000, 3'b000, 2'b00, 0, "rr_drop_idle");
`else
      for (int i = 0; i < 10; i++) step(0, 3'b111, 3'b001, 2'b00, 1, "rr_a_hold");
      step(0, 3'b110, 3'b000, 2'b00, 0, "rr_gap_a");
      step(0, 3'b110, 3'b010, 2'b01, 1, "rr_b");
      step(0, 3'b000, 3'b000, 2'b01, 0, "rr_drop_gap");
      step(0, 3'b000, 3'b000, 2'b01, 0, "rr_drop_idle");
`endif

      // b requesting continuously
`ifdef MUX_ARB_TIMEOUT_EN
      for (int i = 0; i < 8; i++) step(0, 3'b010, 3'b010, 2'b01, 1, "solo_b");
      step(0, 3'b010, 3'b000, 2'b01, 0, "solo_b_timeout_gap");
      for (int i = 0; i < 8; i++) step(0, 3'b010, 3'b010, 2'b01, 1, "solo_b_regrant");
      step(0, 3'b010, 3'b000, 2'b01, 0, "solo_b_timeout_gap2");
`else
      for (int i = 0; i < 55; i++) step(0, 3'b010, 3'b010, 2'b01, 1, "solo_b_hold");
`endif
      step(0, 3'b000, 3'b000, 2'b01, 0, "solo_b_drop");
      step(0, 3'b000, 3'b000, 2'b01, 0, "solo_b_idle");

      // Reset while c owns, then a wins first from req=111
      step(0, 3'b100, 3'b100, 2'b10, 1, "c_own");
      step(0, 3'b100, 3'b100, 2'b10, 1, "c_own2");
      step(1, 3'b111, 3'b000, 2'b00, 0, "mid_reset");
      step(0, 3'b111, 3'b001, 2'b00, 1, "post_reset_a");
      step(0, 3'b000, 3'b000, 2'b00, 0, "post_reset_gap");
      step(0, 3'b000, 3'b000, 2'b00, 0, "post_reset_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
